mod_enc_key_expansion: RTL and testbench
========================================

// Module: mod_enc_key_expansion
// PURPOSE
//  AES-256 key schedule (FIPS-197 sec. 5.2) for the encryption datapath.
//  Takes a 256-bit cipher key and expands it into 60 words (15 round keys).
//  Computes one word per cycle and stores all round keys.
//  Serves any round key by index. rk_kexp connects directly to inp_key_addRK of mod_enc_addRoundKey.
// PARAMETERS
//  NK     8   key length in 32-bit words (fixed for AES-256)
//  NR     14  number of rounds; round keys 0..NR
//  NWORDS 60  4*(NR+1) schedule words
// PORTS
//  clk              in   1    clock, rising edge
//  resetn           in   1    synchronous, ACTIVE-HIGH reset; name kept for codebase uniformity
//  start_kexp       in   1    1-cycle request; sampled only when busy_kexp=0
//  key_kexp         in   256  cipher key; FIPS byte j at [8j+:8]; sampled with start
//  busy_kexp        out  1    expansion in progress
//  keys_valid_kexp  out  1    all 15 round keys valid (level)
//  rk_idx_kexp      in   4    round-key index 0..14
//  rk_kexp          out  128  round key; FIPS byte j at [8j+:8] (AddRoundKey byte order)
// BEHAVIOUR
//  Reset (resetn=1 at an edge): state=IDLE, busy=0, keys_valid=0, rk_kexp=0, word store=0.
//   Reset overrides everything, including mid-expansion; partial keys are discarded.
//  FSM states:
//   IDLE: keys_valid=0. On start, load w[0..7] from key_kexp, set i=8, go to EXPAND.
//   EXPAND: busy=1. Each cycle writes w[i] and increments i.
//    After w[59] is written, go to DONE.
//   DONE: keys_valid=1, busy=0. On start, clear keys_valid in the same edge, reload w[0..7], go to EXPAND.
//  start while busy=1 is ignored; the current expansion is unaffected.
//  Word rule, with t=w[i-1]:
//   i%8==0: w[i]=w[i-8]^SubWord(RotWord(t))^{Rcon[i/8],00,00,00}
//   i%8==4: w[i]=w[i-8]^SubWord(t)
//   else:   w[i]=w[i-8]^t
//   RotWord: [a0,a1,a2,a3] -> [a1,a2,a3,a0]. Rcon[1..7] = 01,02,04,08,10,20,40.
//   Word w[i] holds FIPS bytes 4i..4i+3. Byte 4i is stored in the word's LS byte [7:0].
//  Latency: keys_valid rises 53 edges after the edge that samples start (1 load edge + 52 expand edges).
//  Read port:
//   rk_kexp <= {w[4r+3],w[4r+2],w[4r+1],w[4r]} for r=rk_idx, with 1-cycle registered latency.
//   Reads are always performed, even when keys_valid=0 (returns current contents).
//   If rk_idx>14, rk_kexp <= 0.
//   A read and a write to the same word in one cycle return the OLD value.
//  The consumer must not use rk_kexp unless keys_valid=1 was seen at the read request.
// STRUCTURE
//  Package aes_pkg:
//   typedef logic [7:0] byte_t; typedef logic [31:0] word_t;
//   localparam NK/NR/NWORDS; RCON table (byte_t array [1:7]).
//   enum kexp_state_t {IDLE, EXPAND, DONE}.
//  Sub-module mod_sbox: combinational, 8-bit in/out. Instantiated x4 to form SubWord.
//   This is the same block the SubBytes stage uses.
//  Word store: 60 x word_t flop array; 6-bit word counter.
// TESTING
//  Key used below (FIPS-197 A.3): 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4.
//  T1 reset: hold resetn=1 for 2 cycles -> busy=0, keys_valid=0, rk_kexp=0.
//  T2 FIPS A.3 key, start, wait for keys_valid:
//   keys_valid rises exactly 53 edges after start.
//   idx1 -> 1f352c073b6108d72d9810a30914dff4
//   idx2 -> 9ba354118e6925afa51a8b5f2067fcde
//   idx14 -> fe4890d1e6188d0b046df344706c631e (FIPS byte order)
//  T3 start pulsed again at expansion cycle 20 with a different key -> ignored; T2 results unchanged.
//  T4 resetn=1 at cycle 30 of expansion:
//   next cycle busy=0, keys_valid=0, rk_kexp=0.
//   A new start then gives T2 results.
//  T5 read idx=15 -> rk_kexp=0. Read idx=0 while in EXPAND -> returns the loaded key bytes 0..15.
//  T6 restart from DONE with an all-zero key:
//   keys_valid drops at the start edge and returns at edge 53.
//   idx2 -> 62636363626363636263636362636363.

Source files
------------

// File: rtl/aes_pkg.sv
// AES shared types, schedule constants and GF(2^8) helper.
// Used by the key schedule and the SubBytes S-box.
package aes_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    localparam int NK     = 8;
    localparam int NR     = 14;
    localparam int NWORDS = 4 * (NR + 1);

    localparam byte_t RCON [1:7] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } kexp_state_t;

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k])
                p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/mod_sbox.sv
// AES S-box: multiplicative inverse (x^254) followed by the affine map.
// Purely combinational; shared with the SubBytes stage.
module mod_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] sub_data
);

    byte_t sq;
    byte_t inv;

    always_comb begin
        sq  = data;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        sub_data = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: rtl/mod_enc_key_expansion.sv
// AES-256 key schedule: one word per cycle into a 60-word store,
// with a registered round-key read port.
module mod_enc_key_expansion
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         start_kexp,
    input  logic [255:0] key_kexp,
    output logic         busy_kexp,
    output logic         keys_valid_kexp,
    input  logic [3:0]   rk_idx_kexp,
    output logic [127:0] rk_kexp
);

    kexp_state_t state;
    kexp_state_t state_nxt;

    word_t      w [NWORDS];
    logic [5:0] widx;
    logic [5:0] base;
    logic       load;

    word_t t;
    word_t prev;
    word_t sub_in;
    word_t sub_out;
    word_t w_new;
    byte_t rc;

    assign busy_kexp       = (state == EXPAND);
    assign keys_valid_kexp = (state == DONE);
    assign load            = start_kexp && (state != EXPAND);
    assign base            = {rk_idx_kexp, 2'b00};

    always_ff @(posedge clk) begin
        if (resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_kexp) state_nxt = EXPAND;
            EXPAND:  if (widx == 6'(NWORDS - 1)) state_nxt = DONE;
            DONE:    if (start_kexp) state_nxt = EXPAND;
            default: state_nxt = IDLE;
        endcase
    end

    // widx stays within 8..59, so both taps are always in range
    assign t      = w[widx - 6'd1];
    assign prev   = w[widx - 6'd8];
    assign sub_in = (widx[2:0] == 3'd0) ? {t[7:0], t[31:8]} : t;
    assign rc     = (widx[5:3] == 3'd0) ? 8'h00 : RCON[widx[5:3]];

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        mod_sbox u_sbox (
            .data     (sub_in[8*g +: 8]),
            .sub_data (sub_out[8*g +: 8])
        );
    end

    always_comb begin
        w_new = prev ^ t;
        unique case (1'b1)
            (widx[2:0] == 3'd0): w_new = prev ^ sub_out ^ {24'h0, rc};
            (widx[2:0] == 3'd4): w_new = prev ^ sub_out;
            default:             w_new = prev ^ t;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            for (int k = 0; k < NWORDS; k++)
                w[k] <= '0;
            widx    <= 6'(NK);
            rk_kexp <= '0;
        end else begin
            if (load) begin
                for (int k = 0; k < NK; k++)
                    w[k] <= key_kexp[32*k +: 32];
                widx <= 6'(NK);
            end else if (state == EXPAND) begin
                w[widx] <= w_new;
                if (widx != 6'(NWORDS - 1))
                    widx <= widx + 6'd1;
            end
            if (rk_idx_kexp <= 4'(NR))
                rk_kexp <= {w[base + 6'd3], w[base + 6'd2],
                            w[base + 6'd1], w[base]};
            else
                rk_kexp <= '0;
        end
    end

endmodule

// File: tb/tb_mod_enc_key_expansion.sv
// Self-checking bench for the AES-256 key schedule.
// Known-answer round keys from FIPS-197 A.3 and the all-zero key.
module tb_mod_enc_key_expansion;

    logic         clk;
    logic         resetn;
    logic         start_kexp;
    logic [255:0] key_kexp;
    logic         busy_kexp;
    logic         keys_valid_kexp;
    logic [3:0]   rk_idx_kexp;
    logic [127:0] rk_kexp;

    mod_enc_key_expansion dut (
        .clk             (clk),
        .resetn          (resetn),
        .start_kexp      (start_kexp),
        .key_kexp        (key_kexp),
        .busy_kexp       (busy_kexp),
        .keys_valid_kexp (keys_valid_kexp),
        .rk_idx_kexp     (rk_idx_kexp),
        .rk_kexp         (rk_kexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    typedef struct {
        logic [127:0] exp;
        int           tag;
    } sb_t;

    int checks   = 0;
    int failures = 0;
    sb_t sb [$];

    logic [255:0] ka3;
    logic [255:0] kalt;
    vec_t tab_a3 [5];
    vec_t tab_z  [5];

    function automatic logic [127:0] bs128(input logic [127:0] x);
        logic [127:0] r;
        for (int j = 0; j < 16; j++)
            r[8*j +: 8] = x[8*(15-j) +: 8];
        return r;
    endfunction

    function automatic logic [255:0] bs256(input logic [255:0] x);
        logic [255:0] r;
        for (int j = 0; j < 32; j++)
            r[8*j +: 8] = x[8*(31-j) +: 8];
        return r;
    endfunction

    task automatic chk(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("read_tag%0d", e.tag), rk_kexp, e.exp);
        end
    endtask

    task automatic drive_read(input logic [3:0] idx,
                              input logic [127:0] exp,
                              input int tag);
        sb_t e;
        rk_idx_kexp = idx;
        e.exp = exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic start_exp(input logic [255:0] k);
        start_kexp = 1'b1;
        key_kexp   = k;
        tick();
        start_kexp = 1'b0;
    endtask

    task automatic wait_valid(input int n0, input string name);
        int n;
        n = n0;
        while (!keys_valid_kexp && n < 200) begin
            tick();
            n++;
        end
        chk(name, 128'(n), 128'd53);
        chk({name, "_busy"}, 128'(busy_kexp), 128'd0);
    endtask

    task automatic run_table(input int which, input int tag0);
        vec_t v;
        for (int i = 0; i < 5; i++) begin
            v = (which == 0) ? tab_a3[i] : tab_z[i];
            drive_read(v.idx, v.exp, tag0 + i);
            tick();
        end
    endtask

    initial begin
        ka3  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        kalt = 256'hdeadbeef0123456789abcdeffedcba9876543210a5a5a5a55a5a5a5a0f0f0f0f;

        tab_a3[0].idx = 4'd0;
        tab_a3[0].exp = bs128(ka3[255:128]);
        tab_a3[1].idx = 4'd1;
        tab_a3[1].exp = bs128(128'h1f352c073b6108d72d9810a30914dff4);
        tab_a3[2].idx = 4'd2;
        tab_a3[2].exp = bs128(128'h9ba354118e6925afa51a8b5f2067fcde);
        tab_a3[3].idx = 4'd14;
        tab_a3[3].exp = bs128(128'hfe4890d1e6188d0b046df344706c631e);
        tab_a3[4].idx = 4'd15;
        tab_a3[4].exp = '0;

        tab_z[0].idx = 4'd0;
        tab_z[0].exp = '0;
        tab_z[1].idx = 4'd1;
        tab_z[1].exp = '0;
        tab_z[2].idx = 4'd2;
        tab_z[2].exp = bs128(128'h62636363626363636263636362636363);
        tab_z[3].idx = 4'd3;
        tab_z[3].exp = bs128(128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb);
        tab_z[4].idx = 4'd15;
        tab_z[4].exp = '0;

        resetn      = 1'b1;
        start_kexp  = 1'b0;
        key_kexp    = '0;
        rk_idx_kexp = 4'd0;

        // reset state
        repeat (2) tick();
        chk("rst_busy",  128'(busy_kexp),       128'd0);
        chk("rst_valid", 128'(keys_valid_kexp), 128'd0);
        chk("rst_rk",    rk_kexp,               128'd0);
        resetn = 1'b0;
        tick();

        // first expansion with FIPS A.3 key
        start_exp(bs256(ka3));
        chk("t2_busy",  128'(busy_kexp),       128'd1);
        chk("t2_valid", 128'(keys_valid_kexp), 128'd0);
        wait_valid(1, "t2_lat");
        run_table(0, 100);

        // restart from DONE; stray start mid-expansion is ignored
        start_exp(bs256(ka3));
        chk("t3_valid_drop", 128'(keys_valid_kexp), 128'd0);
        repeat (18) tick();
        start_kexp = 1'b1;
        key_kexp   = bs256(kalt);
        drive_read(4'd0, bs128(ka3[255:128]), 200);
        tick();
        start_kexp = 1'b0;
        chk("t3_busy", 128'(busy_kexp), 128'd1);
        wait_valid(20, "t3_lat");
        run_table(0, 300);

        // reset in the middle of an expansion
        start_exp(bs256(ka3));
        repeat (29) tick();
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        chk("t4_busy",  128'(busy_kexp),       128'd0);
        chk("t4_valid", 128'(keys_valid_kexp), 128'd0);
        chk("t4_rk",    rk_kexp,               128'd0);
        start_exp(bs256(ka3));
        drive_read(4'd0, bs128(ka3[255:128]), 400);
        tick();
        drive_read(4'd1, bs128(ka3[127:0]), 401);
        tick();
        wait_valid(3, "t4_lat");
        run_table(0, 500);

        // restart from DONE with the all-zero key
        chk("t6_pre_valid", 128'(keys_valid_kexp), 128'd1);
        start_exp('0);
        chk("t6_valid_drop", 128'(keys_valid_kexp), 128'd0);
        wait_valid(1, "t6_lat");
        run_table(1, 600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
